// File: rtl/myriadrf_rx_ctrl.sv
// MyriadRF receive-side control: sign-extends 12-bit I/Q samples into 32-bit words, buffers
// them in a small FIFO and DMA-writes them to memory over a Wishbone master.
module myriadrf_rx_ctrl #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic        irq_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  localparam int unsigned Depth = 1 << FIFO_AW;

  typedef enum logic [1:0] {StIdle, StWrite, StRetry} state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d, abort_q, abort_d;
  logic               overflow_q, overflow_d, done_q, done_d, bus_err_q, bus_err_d;
  logic               irq_q, irq_d, wbs_ack_q, wbs_ack_d;
  logic [31:0]        wbs_dat_q, wbs_dat_d;
  logic [31:0]        start_addr_q, start_addr_d, buf_size_q, buf_size_d;
  logic [31:0]        wr_cnt_q, wr_cnt_d, push_cnt_q, push_cnt_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]        mem_q [Depth];

  logic        fifo_empty, fifo_full, want, push, drop, flush;
  logic        wbs_req, reg_wr, in_write;
  logic [2:0]  reg_idx;
  logic [31:0] bmask, sample_word, fifo_head;
  logic        unused_inputs;

  assign unused_inputs = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_cti_i, wbs_bte_i, wbm_dat_i};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  assign sample_word = {{4{s_data_i[23]}}, s_data_i[23:12], {4{s_data_i[11]}}, s_data_i[11:0]};

  // The source never stalls: a full FIFO drops the sample and flags overflow instead.
  assign want = s_valid_i & busy_q & (push_cnt_q < buf_size_q);
  assign push = want & ~abort_q & ~fifo_full;
  assign drop = want & fifo_full;

  assign wbs_req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_q;
  assign reg_wr  = wbs_req & wbs_we_i;
  assign reg_idx = wbs_adr_i[4:2];
  assign bmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    abort_d      = abort_q;
    overflow_d   = overflow_q;
    done_d       = done_q;
    bus_err_d    = bus_err_q;
    start_addr_d = start_addr_q;
    buf_size_d   = buf_size_q;
    wr_cnt_d     = wr_cnt_q;
    push_cnt_d   = push_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wbs_ack_d    = wbs_req;
    wbs_dat_d    = '0;
    irq_d        = done_q | bus_err_q;
    flush        = 1'b0;

    if (wbs_req && !wbs_we_i) begin
      case (reg_idx)
        3'd0:    wbs_dat_d = {31'b0, busy_q};
        3'd1:    wbs_dat_d = start_addr_q;
        3'd2:    wbs_dat_d = buf_size_q;
        3'd3:    wbs_dat_d = {28'b0, bus_err_q, done_q, overflow_q, busy_q};
        3'd4:    wbs_dat_d = wr_cnt_q;
        default: wbs_dat_d = '0;
      endcase
    end

    if (reg_wr) begin
      case (reg_idx)
        3'd0: begin
          if (wbs_sel_i[0]) begin
            if (wbs_dat_i[0] && !busy_q) begin
              wr_cnt_d   = '0;
              push_cnt_d = '0;
              if (buf_size_q == '0) done_d = 1'b1;
              else                  busy_d = 1'b1;
            end else if (!wbs_dat_i[0] && busy_q) begin
              abort_d = 1'b1;
            end
          end
        end
        3'd1: start_addr_d = ((start_addr_q & ~bmask) | (wbs_dat_i & bmask)) & 32'hFFFF_FFFC;
        3'd2: buf_size_d   = (buf_size_q & ~bmask) | (wbs_dat_i & bmask);
        3'd3: begin
          if (wbs_sel_i[0]) begin
            overflow_d = overflow_q & ~wbs_dat_i[1];
            done_d     = done_q & ~wbs_dat_i[2];
            bus_err_d  = bus_err_q & ~wbs_dat_i[3];
          end
        end
        default: ;
      endcase
    end

    if (push) begin
      push_cnt_d = push_cnt_q + 32'd1;
      wr_ptr_d   = wr_ptr_q + 1'b1;
    end
    if (drop) overflow_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        // An abort settles only here, so a write already on the bus always completes first.
        if (busy_q && abort_q) begin
          flush   = 1'b1;
          busy_d  = 1'b0;
          abort_d = 1'b0;
        end else if (busy_q && !fifo_empty) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (wbm_err_i) begin
          bus_err_d = 1'b1;
          flush     = 1'b1;
          busy_d    = 1'b0;
          abort_d   = 1'b0;
          state_d   = StIdle;
        end else if (wbm_ack_i) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          wr_cnt_d = wr_cnt_q + 32'd1;
          state_d  = StIdle;
          if (!abort_q && (wr_cnt_q + 32'd1 == buf_size_q)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end else if (wbm_rty_i) begin
          state_d = StRetry;
        end
      end
      StRetry: state_d = StWrite;
      default: state_d = StIdle;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      abort_q      <= 1'b0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      bus_err_q    <= 1'b0;
      irq_q        <= 1'b0;
      wbs_ack_q    <= 1'b0;
      wbs_dat_q    <= '0;
      start_addr_q <= '0;
      buf_size_q   <= '0;
      wr_cnt_q     <= '0;
      push_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      abort_q      <= abort_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
      bus_err_q    <= bus_err_d;
      irq_q        <= irq_d;
      wbs_ack_q    <= wbs_ack_d;
      wbs_dat_q    <= wbs_dat_d;
      start_addr_q <= start_addr_d;
      buf_size_q   <= buf_size_d;
      wr_cnt_q     <= wr_cnt_d;
      push_cnt_q   <= push_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= sample_word;
  end

  assign in_write  = (state_q == StWrite);
  assign wbm_cyc_o = in_write;
  assign wbm_stb_o = in_write;
  assign wbm_we_o  = in_write;
  assign wbm_sel_o = {4{in_write}};
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign wbm_adr_o = in_write ? (start_addr_q + {wr_cnt_q[29:0], 2'b00}) : '0;
  assign wbm_dat_o = in_write ? fifo_head : '0;

  assign s_ready_o = 1'b1;
  assign wbs_ack_o = wbs_ack_q;
  assign wbs_dat_o = wbs_dat_q;
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_myriadrf_rx_ctrl.sv
// Directed bench for myriadrf_rx_ctrl: register bank, sample packing, DMA writes,
// overflow, retry, bus error, abort, zero-length capture and asynchronous reset.
module tb_myriadrf_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o, irq_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

  int checks = 0;
  int errors = 0;

  // Memory-side model state
  logic [31:0] log_adr [$];
  logic [31:0] log_dat [$];
  logic [31:0] base_addr = 32'h0;
  int          stall = 0;
  int          err_word = -1;
  int          rty_word = -1;
  int          rty_done = 0;
  int          cyc_num = 0;
  int          cyc_seen = 0;
  int          rty_cyc = 0;
  int          ack_cyc = 0;
  logic [31:0] rty_adr = '0;
  logic [31:0] rty_dat = '0;

  myriadrf_rx_ctrl #(.FIFO_AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cti_i (wbs_cti_i),
    .wbs_bte_i (wbs_bte_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .wbs_err_o (wbs_err_o),
    .wbs_rty_o (wbs_rty_o),
    .irq_o     (irq_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cti_o (wbm_cti_o),
    .wbm_bte_o (wbm_bte_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .wbm_rty_i (wbm_rty_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output logic [31:0] rdat);
    int n = 0;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = 4'hF;
    wbs_we_i  = we;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    rdat      = '0;
    while (n < 8) begin
      tick(1);
      n++;
      if (wbs_ack_o) break;
    end
    if (!wbs_ack_o) chk("wbs_ack_timeout", {31'b0, wbs_ack_o}, 32'd1);
    rdat      = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_access(1'b1, adr, dat, dummy);
  endtask

  task automatic wb_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    wb_access(1'b0, adr, 32'h0, r);
    chk(tag, r, exp);
  endtask

  task automatic feed(input logic [23:0] d, input int gap);
    s_data_i  = d;
    s_valid_i = 1'b1;
    tick(1);
    s_valid_i = 1'b0;
    tick(gap);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n = 0;
    while (!irq_o && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, {31'b0, irq_o}, 32'd1);
  endtask

  task automatic wait_log(input string tag, input int cnt, input int budget);
    int n = 0;
    while (log_adr.size() < cnt && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, log_adr.size(), cnt);
  endtask

  // Memory responder: answers each master request one cycle after it appears.
  initial begin
    int widx;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc_num++;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_rty_i = 1'b0;
      if (wbm_cyc_o && wbm_stb_o) begin
        cyc_seen++;
        widx = int'((wbm_adr_o - base_addr) >> 2);
        if (stall == 0) begin
          if (widx == err_word) begin
            wbm_err_i = 1'b1;
          end else if (widx == rty_word && rty_done == 0) begin
            wbm_rty_i = 1'b1;
            rty_done  = 1;
            rty_cyc   = cyc_num;
            rty_adr   = wbm_adr_o;
            rty_dat   = wbm_dat_o;
          end else begin
            wbm_ack_i = 1'b1;
            log_adr.push_back(wbm_adr_o);
            log_dat.push_back(wbm_dat_o);
            if (widx == rty_word) ack_cyc = cyc_num;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    rst       = 1'b1;
    s_data_i  = '0;
    s_valid_i = 1'b0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    wbs_sel_i = '0;
    wbs_we_i  = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_cti_i = '0;
    wbs_bte_i = '0;

    // Reset state
    #2;
    chk("rst_s_ready", {31'b0, s_ready_o}, 32'd1);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    chk("rst_wbm_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("rst_wbs_ack", {31'b0, wbs_ack_o}, 32'd0);
    chk("rst_wbm_adr", wbm_adr_o, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    wb_check("rst_status", 32'h0C, 32'h0);
    wb_check("rst_wr_count", 32'h10, 32'h0);
    wb_check("rst_unmapped", 32'h1C, 32'h0);

    // Basic capture of four samples
    base_addr = 32'h1000;
    wb_write(32'h04, 32'h0000_1003);
    wb_check("start_addr_lsb_forced", 32'h04, 32'h0000_1000);
    wb_write(32'h08, 32'd4);
    wb_write(32'h00, 32'd1);
    wb_check("basic_busy", 32'h00, 32'h1);
    feed(24'h7FF801, 0);
    feed(24'h001FFF, 0);
    feed(24'h800000, 0);
    feed(24'h123456, 0);
    wait_irq("basic_irq", 60);
    wait_log("basic_log_size", 4, 10);
    chk("basic_adr0", log_adr[0], 32'h0000_1000);
    chk("basic_adr1", log_adr[1], 32'h0000_1004);
    chk("basic_adr2", log_adr[2], 32'h0000_1008);
    chk("basic_adr3", log_adr[3], 32'h0000_100C);
    chk("basic_dat0", log_dat[0], 32'h07FF_F801);
    chk("basic_dat1", log_dat[1], 32'h0001_FFFF);
    chk("basic_dat2", log_dat[2], 32'hF800_0000);
    chk("basic_dat3", log_dat[3], 32'h0123_0456);
    wb_check("basic_status", 32'h0C, 32'h4);
    wb_check("basic_wr_count", 32'h10, 32'd4);
    wb_write(32'h0C, 32'h4);
    tick(1);
    chk("basic_irq_cleared", {31'b0, irq_o}, 32'd0);

    // Overflow with stalled memory
    log_adr.delete();
    log_dat.delete();
    base_addr = 32'h2000;
    stall = 1;
    wb_write(32'h04, 32'h2000);
    wb_write(32'h08, 32'd64);
    wb_write(32'h00, 32'd1);
    for (int i = 0; i < 40; i++) feed(24'(i), 0);
    wb_check("ovf_status_set", 32'h0C, 32'h3);
    wb_write(32'h0C, 32'h2);
    wb_check("ovf_status_cleared", 32'h0C, 32'h1);
    stall = 0;
    wait_log("ovf_drain", 16, 100);
    chk("ovf_adr0", log_adr[0], 32'h0000_2000);
    chk("ovf_dat15", log_dat[15], 32'h0000_000F);
    chk("ovf_adr15", log_adr[15], 32'h0000_203C);
    for (int i = 0; i < 48; i++) feed(24'(100 + i), 1);
    wait_irq("ovf_irq", 300);
    chk("ovf_log_size", log_adr.size(), 32'd64);
    chk("ovf_dat16", log_dat[16], 32'h0000_0064);
    chk("ovf_adr16", log_adr[16], 32'h0000_2040);
    chk("ovf_dat63", log_dat[63], 32'h0000_0093);
    wb_check("ovf_final_status", 32'h0C, 32'h4);
    wb_check("ovf_wr_count", 32'h10, 32'd64);
    wb_write(32'h0C, 32'h4);

    // Retry on first attempt of word 2
    log_adr.delete();
    log_dat.delete();
    base_addr = 32'h3000;
    rty_word  = 2;
    rty_done  = 0;
    wb_write(32'h04, 32'h3000);
    wb_write(32'h08, 32'd4);
    wb_write(32'h00, 32'd1);
    for (int i = 0; i < 4; i++) feed(24'h001000 + 24'(i), 1);
    wait_irq("rty_irq", 100);
    chk("rty_seen", rty_done, 32'd1);
    chk("rty_adr", rty_adr, 32'h0000_3008);
    chk("rty_dat", rty_dat, 32'h0001_0002);
    chk("rty_reissue_adr", log_adr[2], 32'h0000_3008);
    chk("rty_reissue_dat", log_dat[2], 32'h0001_0002);
    chk("rty_gap", ack_cyc - rty_cyc, 32'd2);
    wb_check("rty_wr_count", 32'h10, 32'd4);
    rty_word = -1;
    wb_write(32'h0C, 32'h4);

    // Bus error on word 1 of 8
    log_adr.delete();
    log_dat.delete();
    base_addr = 32'h4000;
    err_word  = 1;
    wb_write(32'h04, 32'h4000);
    wb_write(32'h08, 32'd8);
    wb_write(32'h00, 32'd1);
    for (int i = 0; i < 8; i++) feed(24'h002000 + 24'(i), 1);
    wait_irq("err_irq", 100);
    wb_check("err_status", 32'h0C, 32'h8);
    wb_check("err_wr_count", 32'h10, 32'd1);
    chk("err_log_size", log_adr.size(), 32'd1);
    snap = cyc_seen;
    for (int i = 0; i < 4; i++) feed(24'h003000, 1);
    tick(10);
    chk("err_no_more_cyc", cyc_seen, snap);
    err_word = -1;
    wb_write(32'h0C, 32'h8);
    tick(1);
    chk("err_irq_cleared", {31'b0, irq_o}, 32'd0);

    // Abort with a pending transfer
    log_adr.delete();
    log_dat.delete();
    base_addr = 32'h5000;
    stall = 1;
    wb_write(32'h04, 32'h5000);
    wb_write(32'h08, 32'd8);
    wb_write(32'h00, 32'd1);
    for (int i = 0; i < 3; i++) feed(24'h004000 + 24'(i), 1);
    chk("abort_pending_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    wb_write(32'h00, 32'd0);
    wb_check("abort_still_busy", 32'h0C, 32'h1);
    feed(24'h005000, 1);
    stall = 0;
    tick(20);
    chk("abort_log_size", log_adr.size(), 32'd1);
    chk("abort_adr0", log_adr[0], 32'h0000_5000);
    wb_check("abort_wr_count", 32'h10, 32'd1);
    wb_check("abort_status", 32'h0C, 32'h0);
    chk("abort_irq", {31'b0, irq_o}, 32'd0);
    wb_write(32'h00, 32'd1);
    wb_check("restart_wr_count", 32'h10, 32'd0);
    wb_check("restart_busy", 32'h00, 32'h1);
    wb_write(32'h00, 32'd0);
    tick(3);
    wb_check("restart_abort_status", 32'h0C, 32'h0);

    // Zero-length capture
    wb_write(32'h08, 32'd0);
    snap = cyc_seen;
    wb_write(32'h00, 32'd1);
    tick(1);
    chk("zero_irq", {31'b0, irq_o}, 32'd1);
    wb_check("zero_status", 32'h0C, 32'h4);
    tick(5);
    chk("zero_no_cyc", cyc_seen, snap);
    wb_write(32'h0C, 32'h4);

    // Asynchronous reset in the middle of a write
    base_addr = 32'h7000;
    stall = 1;
    wb_write(32'h04, 32'h7000);
    wb_write(32'h08, 32'd4);
    wb_write(32'h00, 32'd1);
    feed(24'h006001, 0);
    for (int i = 0; i < 20 && !wbm_cyc_o; i++) tick(1);
    chk("arst_pre_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("arst_stb", {31'b0, wbm_stb_o}, 32'd0);
    chk("arst_adr", wbm_adr_o, 32'd0);
    chk("arst_dat", wbm_dat_o, 32'd0);
    chk("arst_sel", {28'b0, wbm_sel_o}, 32'd0);
    stall = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
    wb_check("arst_buf_size", 32'h08, 32'd0);
    wb_check("arst_start_addr", 32'h04, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
